// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter: shares the single MMU request port between the L1 I-cache
// and the L1 D-cache. One requester is granted at a time, its request is
// forwarded unchanged, and mmu_done is steered back only to the granted cache.
// A one-cycle RELEASE state after every completion guarantees the MMU sees
// its request deassert between transactions. A sticky watchdog flags grants
// that wait too long for mmu_done without aborting them.
module l1_mmu_arbiter #(
    parameter int RR_ENABLE = 1,
    parameter int TIMEOUT   = 4096,
    parameter int TO_W      = 16
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         ic_req_read,
    input  logic [31:0]  ic_req_addr,
    output logic         ic_done,
    output logic [255:0] ic_read_data,
    input  logic         dc_req_read,
    input  logic         dc_req_write,
    input  logic [31:0]  dc_req_addr,
    input  logic [255:0] dc_write_data,
    output logic         dc_done,
    output logic [255:0] dc_read_data,
    output logic         mmu_req_read,
    output logic         mmu_req_write,
    output logic [31:0]  mmu_req_addr,
    output logic [255:0] mmu_write_data,
    input  logic         mmu_done,
    input  logic [255:0] mmu_read_data,
    output logic         grant_d,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Encoding of the most recently granted requester.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);
    localparam logic            WD_EN     = (TIMEOUT != 0);
    localparam logic            RR_ON     = (RR_ENABLE != 0);

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic ireq_s;
    logic dreq_s;
    logic in_grant_s;

    assign ireq_s     = ic_req_read;
    assign dreq_s     = dc_req_read | dc_req_write;
    assign in_grant_s = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);

    // Next-state, arbitration and watchdog computation.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ireq_s && dreq_s) begin
                    // On a tie, round-robin serves whoever was not served last;
                    // fixed priority always favours the D-cache.
                    if (RR_ON && (last_q == SEL_D)) begin
                        state_d = ST_GRANT_I;
                        last_d  = SEL_I;
                    end else begin
                        state_d = ST_GRANT_D;
                        last_d  = SEL_D;
                    end
                    cnt_d = '0;
                end else if (ireq_s) begin
                    state_d = ST_GRANT_I;
                    last_d  = SEL_I;
                    cnt_d   = '0;
                end else if (dreq_s) begin
                    state_d = ST_GRANT_D;
                    last_d  = SEL_D;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (mmu_done) begin
                    state_d = ST_RELEASE;
                end else if (WD_EN && (cnt_q != TIMEOUT_C)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The flag is sticky: only reset clears it.
        if (WD_EN && in_grant_s && (cnt_d == TIMEOUT_C)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Forward the granted requester to the MMU and steer mmu_done back to it.
    always_comb begin
        mmu_req_read   = 1'b0;
        mmu_req_write  = 1'b0;
        mmu_req_addr   = 32'h0000_0000;
        mmu_write_data = 256'd0;
        ic_done        = 1'b0;
        dc_done        = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_GRANT_I: begin
                    mmu_req_read = ic_req_read;
                    mmu_req_addr = ic_req_addr;
                    ic_done      = mmu_done;
                end
                ST_GRANT_D: begin
                    mmu_req_read   = dc_req_read;
                    mmu_req_write  = dc_req_write;
                    mmu_req_addr   = dc_req_addr;
                    mmu_write_data = dc_write_data;
                    dc_done        = mmu_done;
                end
                default: begin
                    mmu_req_read = 1'b0;
                    ic_done      = 1'b0;
                    dc_done      = 1'b0;
                end
            endcase
        end else begin
            mmu_req_read  = 1'b0;
            mmu_req_write = 1'b0;
            ic_done       = 1'b0;
            dc_done       = 1'b0;
        end
    end

    // State, last-granted, watchdog counter and error flag registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= SEL_I;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign grant_d      = (state_q == ST_GRANT_D);
    assign err_timeout  = err_q;
    assign ic_read_data = mmu_read_data;
    assign dc_read_data = mmu_read_data;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Testbench for l1_mmu_arbiter: two instances (round-robin with an 8-cycle
// watchdog, fixed D-priority with the watchdog disabled) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_l1_mmu_arbiter;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         ic_req_read;
    logic [31:0]  ic_req_addr;
    logic         dc_req_read;
    logic         dc_req_write;
    logic [31:0]  dc_req_addr;
    logic [255:0] dc_write_data;
    logic         mmu_done;
    logic [255:0] mmu_read_data;

    logic [1:0]   o_rd, o_wr, o_icd, o_dcd, o_gd, o_err;
    logic [31:0]  o_addr [2];
    logic [255:0] o_wd   [2];
    logic [255:0] o_icrd [2];
    logic [255:0] o_dcrd [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: owner 0=none 1=I 2=D; last 0=I 1=D.
    int m_owner [2];
    int m_gap   [2];
    int m_last  [2];
    int m_wait  [2];
    bit m_err   [2];

    always #5 sys_clk = ~sys_clk;

    l1_mmu_arbiter #(.RR_ENABLE(1), .TIMEOUT(8), .TO_W(16)) u_dut0 (
        .sys_clk(sys_clk), .rst(rst),
        .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr),
        .ic_done(o_icd[0]), .ic_read_data(o_icrd[0]),
        .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_write_data(dc_write_data),
        .dc_done(o_dcd[0]), .dc_read_data(o_dcrd[0]),
        .mmu_req_read(o_rd[0]), .mmu_req_write(o_wr[0]),
        .mmu_req_addr(o_addr[0]), .mmu_write_data(o_wd[0]),
        .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
        .grant_d(o_gd[0]), .err_timeout(o_err[0])
    );

    l1_mmu_arbiter #(.RR_ENABLE(0), .TIMEOUT(0), .TO_W(4)) u_dut1 (
        .sys_clk(sys_clk), .rst(rst),
        .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr),
        .ic_done(o_icd[1]), .ic_read_data(o_icrd[1]),
        .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_write_data(dc_write_data),
        .dc_done(o_dcd[1]), .dc_read_data(o_dcrd[1]),
        .mmu_req_read(o_rd[1]), .mmu_req_write(o_wr[1]),
        .mmu_req_addr(o_addr[1]), .mmu_write_data(o_wd[1]),
        .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
        .grant_d(o_gd[1]), .err_timeout(o_err[1])
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rr_of(input int k);
        return (k == 0);
    endfunction

    function automatic int to_of(input int k);
        return (k == 0) ? 8 : 0;
    endfunction

    task automatic model_reset(input int k);
        m_owner[k] = 0;
        m_gap[k]   = 0;
        m_last[k]  = 0;
        m_wait[k]  = 0;
        m_err[k]   = 1'b0;
    endtask

    // Compare instance k against the model for this cycle, then advance the
    // model across the coming rising edge.
    task automatic model_step(input int k);
        logic         e_rd, e_wr, e_icd, e_dcd, e_gd;
        logic [31:0]  e_addr;
        logic [255:0] e_wd;
        bit           i_req, d_req;
        int           pick;
        if (rst) model_reset(k);
        e_rd = 1'b0; e_wr = 1'b0; e_icd = 1'b0; e_dcd = 1'b0;
        e_addr = 32'h0; e_wd = 256'd0;
        e_gd = (m_owner[k] == 2);
        if (!rst && m_owner[k] == 1) begin
            e_rd = ic_req_read; e_addr = ic_req_addr; e_icd = mmu_done;
        end
        if (!rst && m_owner[k] == 2) begin
            e_rd = dc_req_read; e_wr = dc_req_write; e_addr = dc_req_addr;
            e_wd = dc_write_data; e_dcd = mmu_done;
        end
        check_eq($sformatf("ctl%0d", k), {o_rd[k], o_wr[k], o_icd[k], o_dcd[k], o_gd[k], o_err[k]},
                 {e_rd, e_wr, e_icd, e_dcd, e_gd, m_err[k]});
        check_eq($sformatf("addr%0d", k), o_addr[k], e_addr);
        check_eq($sformatf("wdata%0d", k), o_wd[k], e_wd);
        check_eq($sformatf("ic_rdata%0d", k), o_icrd[k], mmu_read_data);
        check_eq($sformatf("dc_rdata%0d", k), o_dcrd[k], mmu_read_data);
        if (!rst) begin
            if (m_owner[k] != 0) begin
                if (mmu_done) begin
                    m_owner[k] = 0;
                    m_gap[k]   = 1;
                end else if (to_of(k) > 0) begin
                    if (m_wait[k] < to_of(k)) m_wait[k]++;
                    if (m_wait[k] == to_of(k)) m_err[k] = 1'b1;
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k] = 0;
            end else begin
                i_req = ic_req_read;
                d_req = dc_req_read | dc_req_write;
                pick  = 0;
                if (i_req && d_req) pick = (rr_of(k) && m_last[k] == 1) ? 1 : 2;
                else if (i_req)     pick = 1;
                else if (d_req)     pick = 2;
                if (pick != 0) begin
                    m_owner[k] = pick;
                    m_last[k]  = pick - 1;
                    m_wait[k]  = 0;
                end
            end
        end
    endtask

    // One clock: check at the falling edge, return 1 time unit after the rise.
    task automatic tick();
        @(negedge sys_clk);
        model_step(0);
        model_step(1);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ic_req_read = 1'b0; ic_req_addr = 32'h0;
        dc_req_read = 1'b0; dc_req_write = 1'b0; dc_req_addr = 32'h0;
        dc_write_data = 256'd0; mmu_done = 1'b0; mmu_read_data = 256'd0;
        model_reset(0);
        model_reset(1);
        repeat (2) tick();
        check_eq("rst_outs", {o_rd[0], o_wr[0], o_icd[0], o_dcd[0], o_gd[0], o_err[0]}, 6'b000000);
        #1 rst = 1'b0;

        // Single I request, MMU answers after 5 grant cycles.
        ic_req_read = 1'b1; ic_req_addr = 32'h0000_1000;
        tick();
        check_eq("single_rd", o_rd[0], 1'b1);
        check_eq("single_addr", o_addr[0], 32'h0000_1000);
        repeat (4) tick();
        mmu_done = 1'b1;
        #1 check_eq("single_icd", {o_icd[0], o_dcd[0]}, 2'b10);
        tick();
        mmu_done = 1'b0;
        check_eq("single_release", o_rd[0], 1'b0);
        ic_req_read = 1'b0;
        tick();

        // Both requesting continuously: RR alternates D,I,D,I; fixed gives D.
        ic_req_read = 1'b1; ic_req_addr = 32'h0000_2000;
        dc_req_read = 1'b1; dc_req_addr = 32'h0000_3000;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_eq($sformatf("rr_gd%0d", t), o_gd[0], (t % 2 == 0) ? 1'b1 : 1'b0);
            check_eq($sformatf("fix_gd%0d", t), o_gd[1], 1'b1);
            mmu_done = 1'b1;
            tick();
            mmu_done = 1'b0;
            tick();
        end
        ic_req_read = 1'b0; dc_req_read = 1'b0;
        tick();

        // Dirty eviction write followed by a refill read.
        dc_req_write = 1'b1; dc_req_addr = 32'h0040_0020; dc_write_data = {32{8'hA5}};
        tick();
        check_eq("evict_wdata", o_wd[0], {32{8'hA5}});
        check_eq("evict_wr", o_wr[0], 1'b1);
        repeat (2) tick();
        mmu_done = 1'b1;
        tick();
        mmu_done = 1'b0;
        dc_req_write = 1'b0; dc_req_read = 1'b1; dc_req_addr = 32'h8000_0020; dc_write_data = 256'd0;
        check_eq("evict_release", {o_rd[0], o_wr[0]}, 2'b00);
        tick();
        check_eq("evict_idle", o_rd[0], 1'b0);
        tick();
        check_eq("refill_rd", o_rd[0], 1'b1);
        check_eq("refill_addr", o_addr[0], 32'h8000_0020);
        mmu_done = 1'b1;
        tick();
        mmu_done = 1'b0; dc_req_read = 1'b0;
        tick();

        // Spurious mmu_done while idle.
        mmu_done = 1'b1;
        #1 check_eq("spur_done", {o_icd[0], o_dcd[0]}, 2'b00);
        tick();
        mmu_done = 1'b0;
        check_eq("spur_idle", {o_rd[0], o_gd[0]}, 2'b00);

        // Asynchronous reset in the middle of a D grant.
        dc_req_read = 1'b1; dc_req_addr = 32'h0000_1234;
        tick();
        ic_req_read = 1'b1; ic_req_addr = 32'h0000_5000;
        check_eq("pre_rst_gd", o_gd[0], 1'b1);
        #2 rst = 1'b1;
        #1 check_eq("async_rst", {o_rd[0], o_gd[0], o_err[0], o_rd[1]}, 4'b0000);
        tick();
        #1 rst = 1'b0;
        dc_req_read = 1'b0;
        tick();
        check_eq("post_rst_i", {o_rd[0], o_gd[0]}, 2'b10);
        check_eq("post_rst_addr", o_addr[0], 32'h0000_5000);
        mmu_done = 1'b1;
        tick();
        mmu_done = 1'b0; ic_req_read = 1'b0;
        tick();

        // Watchdog: MMU silent for a long I grant.
        ic_req_read = 1'b1; ic_req_addr = 32'h0000_6000;
        tick();
        repeat (7) tick();
        check_eq("wd_before", o_err[0], 1'b0);
        tick();
        check_eq("wd_set", o_err[0], 1'b1);
        repeat (3) tick();
        check_eq("wd_hold", {o_rd[0], o_err[0], o_err[1]}, 3'b110);
        mmu_done = 1'b1;
        #1 check_eq("wd_done", o_icd[0], 1'b1);
        tick();
        mmu_done = 1'b0; ic_req_read = 1'b0;
        check_eq("wd_sticky", o_err[0], 1'b1);
        tick();
        #1 rst = 1'b1;
        tick();
        #1 rst = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            ic_req_read   = ($urandom_range(0, 2) != 0);
            ic_req_addr   = $urandom;
            dc_req_read   = ($urandom_range(0, 2) == 0);
            dc_req_write  = ($urandom_range(0, 3) == 0);
            dc_req_addr   = $urandom;
            dc_write_data = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            mmu_read_data = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            mmu_done      = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_mmu_arbiter.md
Name: l1_mmu_arbiter

Overview:
Shares the single MMU request port between the L1 instruction cache and the L1 data cache. Each requester presents a level-held request (read and/or write, address, 256-bit line) and releases it only after its own done pulse. The arbiter picks one requester, forwards its request unchanged to the MMU, and steers mmu_done back only to the granted cache. It sits between the two L1 caches and the MMU.

Parameters:
RR_ENABLE, 1, 1 = round-robin between I and D; 0 = fixed D-priority
TIMEOUT, 4096, cycles in a GRANT state before err_timeout sets; 0 = watchdog disabled
TO_W, 16, width of the watchdog counter; TIMEOUT must be < 2^TO_W

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ic_req_read  in  1  I-cache line read request, held until ic_done
ic_req_addr  in  32  I-cache request address
ic_done  out  1  done pulse to I-cache
ic_read_data  out  256  read line to I-cache
dc_req_read  in  1  D-cache read request, held until dc_done
dc_req_write  in  1  D-cache write request, held until dc_done
dc_req_addr  in  32  D-cache request address
dc_write_data  in  256  D-cache write line/MMIO word
dc_done  out  1  done pulse to D-cache
dc_read_data  out  256  read line to D-cache
mmu_req_read  out  1  to MMU
mmu_req_write  out  1  to MMU
mmu_req_addr  out  32  to MMU
mmu_write_data  out  256  to MMU
mmu_done  in  1  MMU completion pulse
mmu_read_data  in  256  MMU read data
grant_d  out  1  1 while state = GRANT_D (debug)
err_timeout  out  1  sticky watchdog flag

Behaviour:
- The clock is sys_clk. Reset rst is asynchronous and active-high. Reset sets state=IDLE, last=I, the watchdog counter to 0 and err_timeout=0. All MMU request outputs, ic_done and dc_done are combinationally 0 while rst is high.
- States: IDLE, GRANT_I, GRANT_D, RELEASE. State is registered.
- IDLE: all MMU request outputs are 0, and ic_done=dc_done=0. Define ireq=ic_req_read and dreq=dc_req_read|dc_req_write.
  - Only ireq: next state GRANT_I.
  - Only dreq: next state GRANT_D.
  - Both, RR_ENABLE=1: grant the requester that is not `last`.
  - Both, RR_ENABLE=0: GRANT_D.
  - On entry to a GRANT state, `last` is updated to the granted requester.
  - Arbitration latency is 1 cycle: the request is seen in IDLE and reaches the MMU on the next cycle.
- GRANT_I: the MMU outputs follow the I inputs combinationally.
  - mmu_req_read=ic_req_read, mmu_req_write=0, mmu_req_addr=ic_req_addr, mmu_write_data=0.
  - ic_done=mmu_done, dc_done=0.
- GRANT_D: the MMU outputs follow the D inputs combinationally.
  - mmu_req_read=dc_req_read, mmu_req_write=dc_req_write, mmu_req_addr=dc_req_addr, mmu_write_data=dc_write_data.
  - dc_done=mmu_done, ic_done=0.
  - The D-cache may change addr/read/write between its own done pulses, e.g. dirty flush then refill. The grant is held only until the first mmu_done.
- Leaving GRANT: mmu_done=1 in either GRANT state moves to RELEASE. Grant is never revoked before mmu_done. A requester that drops its request while granted is forwarded as-is, and the grant remains until mmu_done.
- RELEASE: lasts exactly 1 cycle, then IDLE. MMU request outputs are 0 and no done is routed. This guarantees the MMU sees its request deassert between transactions. Minimum spacing between two MMU transactions is therefore RELEASE + IDLE = 2 cycles.
- mmu_done in IDLE or RELEASE is ignored and is not routed to either cache.
- ic_read_data and dc_read_data are both mmu_read_data, ungated. Only the done signals are qualified.
- Watchdog:
  - The counter clears on entering a GRANT state and increments each cycle in GRANT with mmu_done=0, saturating at TIMEOUT.
  - When it equals TIMEOUT and TIMEOUT≠0, err_timeout sets. It is cleared only by rst.
  - No abort: the grant stays in place.
- grant_d=1 iff state=GRANT_D.

Test Plan:
- Single I request, addr 0x0000_1000, MMU responds after 5 cycles:
  - mmu_req_read rises 1 cycle after ic_req_read and mmu_req_addr=0x1000.
  - ic_done pulses with mmu_done, dc_done stays 0.
  - Next cycle is RELEASE with mmu_req_read=0.
- Both request in the same cycle after reset, RR_ENABLE=1:
  - D is served first (last=I at reset), then I.
  - Repeat both requesting: order alternates D,I,D,I.
  - With RR_ENABLE=0, D always wins.
- D dirty eviction: dc_req_write to 0x0040_0020 with data 0xA5.., then, after dc_done, dc_req_read to 0x8000_0020:
  - Two separate grants separated by RELEASE+IDLE.
  - mmu_write_data=0xA5.. during the first grant.
- mmu_done asserted spuriously while in IDLE with ic_req_read=0 and dc requests low -> ic_done=dc_done=0 and state stays IDLE.
- rst pulsed mid GRANT_D, asynchronously and not clock-aligned:
  - mmu_req_* drop to 0 immediately; state=IDLE, err_timeout=0.
  - A pending I request is granted 1 cycle after rst falls.
- TIMEOUT=8, MMU never responds to GRANT_I:
  - err_timeout=1 after 8 grant cycles; the grant stays in place.
  - A later mmu_done still delivers ic_done and err_timeout stays 1.
